sensor_conditioner: RTL and testbench

Front-end stage directly upstream of `home_automation_system`. It takes raw, asynchronous, bouncing door/fire/window/temperature-sensor contacts and a raw 6-bit temperature sample stream, and delivers clean, registered `SFD`, `SRD`, `SFA`, `SW`, `ST` and `temperature[5:0]`. It also produces a one-cycle `sensor_event` pulse whenever any conditioned value changes, for downstream status logging.

---
 rtl/sensor_conditioner.sv | 131 +++++++++++++
 tb/tb_sensor_conditioner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Front-end conditioning for the home automation controller: synchronizes and debounces
// five sensor contacts, averages the temperature stream over four samples, flags output changes.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_sfd,
  input  logic       raw_srd,
  input  logic       raw_sfa,
  input  logic       raw_sw,
  input  logic       raw_st,
  input  logic [5:0] raw_temperature,
  input  logic       temp_valid,
  output logic       SFD,
  output logic       SRD,
  output logic       SFA,
  output logic       SW,
  output logic       ST,
  output logic [5:0] temperature,
  output logic       sensor_event
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    raw_bus;
  logic [4:0]    sync_p0;
  logic [4:0]    sync_p1;
  logic [4:0]    db_out;
  logic [4:0]    db_prev;
  logic [CW-1:0] cnt [5];

  logic [5:0] w0, w1, w2, w3;
  logic [5:0] w0_nxt, w1_nxt, w2_nxt, w3_nxt;
  logic       filled;
  logic [5:0] temp_prev;

  // Sum of four 6-bit values fits in 8 bits; floor divide by four.
  function automatic logic [5:0] avg4(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c, input logic [5:0] d);
    logic [7:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return 6'(sum >> 2);
  endfunction

  assign raw_bus = {raw_st, raw_sw, raw_sfa, raw_srd, raw_sfd};

  // Stage p0/p1: two-flop synchronizer, then per-channel debounce on the p1 value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db_out  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= raw_bus;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == db_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db_out[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // The first accepted sample after reset fills the whole window so the average starts at it.
  always_comb begin
    w0_nxt = w0;
    w1_nxt = w1;
    w2_nxt = w2;
    w3_nxt = w3;
    if (temp_valid) begin
      if (filled) begin
        w0_nxt = raw_temperature;
        w1_nxt = w0;
        w2_nxt = w1;
        w3_nxt = w2;
      end else begin
        w0_nxt = raw_temperature;
        w1_nxt = raw_temperature;
        w2_nxt = raw_temperature;
        w3_nxt = raw_temperature;
      end
    end
  end

  // Stage p0: window update and registered average of the post-update window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0          <= '0;
      w1          <= '0;
      w2          <= '0;
      w3          <= '0;
      filled      <= 1'b0;
      temperature <= '0;
    end else if (temp_valid) begin
      w0          <= w0_nxt;
      w1          <= w1_nxt;
      w2          <= w2_nxt;
      w3          <= w3_nxt;
      filled      <= 1'b1;
      temperature <= avg4(w0_nxt, w1_nxt, w2_nxt, w3_nxt);
    end
  end

  // Stage p2: compare outputs against their previous-cycle copy, so the pulse lags the change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_prev      <= '0;
      temp_prev    <= '0;
      sensor_event <= 1'b0;
    end else begin
      db_prev      <= db_out;
      temp_prev    <= temperature;
      sensor_event <= (db_out != db_prev) || (temperature != temp_prev);
    end
  end

  assign SFD = db_out[0];
  assign SRD = db_out[1];
  assign SFA = db_out[2];
  assign SW  = db_out[3];
  assign ST  = db_out[4];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed vectors plus randomized traffic checked every cycle
// against a queue-based reference model of the debounce, averaging and event rules.
module tb_sensor_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_sfd, raw_srd, raw_sfa, raw_sw, raw_st;
  logic [5:0] raw_temperature;
  logic       temp_valid;
  logic       SFD, SRD, SFA, SW, ST;
  logic [5:0] temperature;
  logic       sensor_event;
  logic [11:0] dut_vec;

  sensor_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .raw_sfd(raw_sfd), .raw_srd(raw_srd), .raw_sfa(raw_sfa), .raw_sw(raw_sw), .raw_st(raw_st),
    .raw_temperature(raw_temperature), .temp_valid(temp_valid),
    .SFD(SFD), .SRD(SRD), .SFA(SFA), .SW(SW), .ST(ST),
    .temperature(temperature), .sensor_event(sensor_event)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ST, SW, SFA, SRD, SFD, temperature, sensor_event};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: raw history queue (two-edge lag), run lengths, sample-list window
  logic [4:0] m_q[$];
  logic [4:0] m_out, m_prev_out;
  int         m_run[5];
  int         m_win[$];
  logic [5:0] m_temp, m_prev_temp;
  logic       m_evt;

  task automatic model_reset();
    m_q = '{5'b0, 5'b0};
    m_out = '0; m_prev_out = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_win.delete();
    m_temp = '0; m_prev_temp = '0;
    m_evt = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] seen;
    int sum;
    m_evt = (m_out != m_prev_out) || (m_temp != m_prev_temp);
    m_prev_out  = m_out;
    m_prev_temp = m_temp;
    m_q.push_back({raw_st, raw_sw, raw_sfa, raw_srd, raw_sfd});
    seen = m_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (seen[i] == m_out[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_out[i] = seen[i];
          m_run[i] = 0;
        end
      end
    end
    if (temp_valid) begin
      if (m_win.size() == 0) repeat (4) m_win.push_back(int'(raw_temperature));
      else begin
        m_win.push_front(int'(raw_temperature));
        m_win = m_win[0:3];
      end
      sum = 0;
      foreach (m_win[j]) sum += m_win[j];
      m_temp = 6'(sum / 4);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model", {4'b0, dut_vec}, {4'b0, m_out, m_temp, m_evt});
    end
  end

  typedef struct {
    logic [5:0] sample;
    logic [5:0] exp_temp;
  } tvec_t;

  tvec_t tv[8];

  initial begin
    int pulses;
    int hold[5];
    logic [4:0] rbits;
    logic b;

    tv[0] = '{6'd20, 6'd20};
    tv[1] = '{6'd24, 6'd21};
    tv[2] = '{6'd28, 6'd23};
    tv[3] = '{6'd32, 6'd26};
    tv[4] = '{6'd63, 6'd36};
    tv[5] = '{6'd63, 6'd46};
    tv[6] = '{6'd63, 6'd55};
    tv[7] = '{6'd63, 6'd63};

    // Reset held with every input active
    reset = 1'b0;
    {raw_st, raw_sw, raw_sfa, raw_srd, raw_sfd} = 5'h1f;
    temp_valid = 1'b1;
    raw_temperature = 6'd63;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("reset_hold", {4'b0, dut_vec}, 16'h0);
    end
    {raw_st, raw_sw, raw_sfa, raw_srd, raw_sfd} = 5'h00;
    temp_valid = 1'b0;
    raw_temperature = 6'd0;
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (6) tick();

    // Clean rising edge on the fire alarm contact
    raw_sfa = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("sfa_edge%0d", k), {15'b0, SFA}, {15'b0, (k >= 5)});
      chk($sformatf("sfa_event%0d", k), {15'b0, sensor_event}, {15'b0, (k == 6)});
    end
    raw_sfa = 1'b0;
    repeat (8) tick();

    // Bouncing window contact never reaches the output, then a steady level does
    foreach (rbits[i]) rbits[i] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      raw_sw = (k == 3 || k == 7) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("sw_bounce%0d", k), {15'b0, SW}, 16'h0);
    end
    raw_sw = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("sw_hold%0d", k), {15'b0, SW}, {15'b0, (k == 5)});
    end
    raw_sw = 1'b0;
    repeat (8) tick();

    // Temperature preload and moving average
    for (int i = 0; i < 8; i++) begin
      temp_valid = 1'b1;
      raw_temperature = tv[i].sample;
      tick();
      chk($sformatf("avg%0d", i), {10'b0, temperature}, {10'b0, tv[i].exp_temp});
    end
    temp_valid = 1'b0;
    raw_temperature = 6'd5;
    tick();
    chk("avg_hold", {10'b0, temperature}, 16'd63);
    repeat (3) tick();

    // Two doors change together: one pulse
    raw_sfd = 1'b1;
    raw_srd = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("merge_pair%0d", k), {14'b0, SFD, SRD}, (k >= 5) ? 16'h3 : 16'h0);
      pulses += int'(sensor_event);
    end
    chk("merge_pulses", 16'(pulses), 16'd1);

    // Repeating the current average produces no pulse
    for (int i = 0; i < 4; i++) begin
      temp_valid = 1'b1;
      raw_temperature = 6'd20;
      tick();
    end
    temp_valid = 1'b0;
    repeat (2) tick();
    chk("refill20", {10'b0, temperature}, 16'd20);
    temp_valid = 1'b1;
    raw_temperature = 6'd20;
    tick();
    temp_valid = 1'b0;
    pulses = 0;
    pulses += int'(sensor_event);
    repeat (3) begin
      tick();
      pulses += int'(sensor_event);
    end
    chk("same_avg_no_pulse", 16'(pulses), 16'd0);

    // Asynchronous reset in the middle of a debounce count
    raw_st = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    raw_sfd = 1'b0;
    raw_srd = 1'b0;
    #1;
    chk("async_reset", {4'b0, dut_vec}, 16'h0);
    @(posedge clk);
    #4 reset = 1'b1;
    temp_valid = 1'b1;
    raw_temperature = 6'd40;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        chk("preload_after_reset", {10'b0, temperature}, 16'd40);
        temp_valid = 1'b0;
      end
      chk($sformatf("st_restart%0d", k), {15'b0, ST}, {15'b0, (k >= 5)});
    end
    raw_st = 1'b0;
    repeat (8) tick();

    // Randomized traffic against the model, with one reset in the middle
    foreach (hold[i]) hold[i] = 0;
    rbits = 5'h00;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          b = 1'($urandom_range(0, 1));
          rbits[i] = b;
          hold[i] = $urandom_range(1, 9);
        end else hold[i]--;
      end
      {raw_st, raw_sw, raw_sfa, raw_srd, raw_sfd} = rbits;
      temp_valid = 1'($urandom_range(0, 1));
      raw_temperature = 6'($urandom_range(0, 63));
      if (c == 700) reset = 1'b0;
      if (c == 703) reset = 1'b1;
      tick();
    end
    {raw_st, raw_sw, raw_sfa, raw_srd, raw_sfd} = 5'h00;
    temp_valid = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
